// File: rtl/sipo_pkg.sv
// Shared constants, counter-width helper and holding-register state for sipo_deserializer.
package sipo_pkg;

  localparam int SIPO_WIDTH = 8;

  // Counter must hold 0..WIDTH so the parity build can count the extra bit.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial shift register; d_next is the value loaded on the next edge.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_next
);

  logic [WIDTH-1:0] q;

  always_comb begin
    // NOTE: default assignment first so every path drives d_next and no latch is inferred.
    d_next = q;
    if (shift_en) begin
      if (MSB_FIRST) d_next = {q[WIDTH-2:0], ser_in};
      else           d_next = {ser_in, q[WIDTH-1:1]};
    end
  end

  // NOTE: non-blocking so every flop samples its pre-edge inputs regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d_next;
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with valid/ready output and serial backpressure.
// Optional even-parity checking is built when SIPO_PARITY_EN is defined (adds par_err).
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  output logic                     ser_ready,
  output logic [WIDTH-1:0]         par_out,
  output logic                     par_valid,
  input  logic                     par_ready,
`ifdef SIPO_PARITY_EN
  output logic                     par_err,
`endif
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt
);

  localparam int CW = cnt_w(WIDTH);
`ifdef SIPO_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  hold_state_e      state;
  logic [WIDTH-1:0] word_next;
  logic             at_last;
  logic             accept;
  logic             complete;
  logic             shift_en;
  logic             pop;

  assign at_last   = (bit_cnt == LAST_CNT);
  assign par_valid = (state == S_FULL);
  assign pop       = par_valid && par_ready;
  // Only the word-completing bit can stall, so a held word is never overwritten.
  assign ser_ready = !(at_last && par_valid && !par_ready);
  assign accept    = ser_valid && ser_ready;
  assign complete  = accept && at_last;

`ifdef SIPO_PARITY_EN
  // The parity bit is not data: freezing the shifter leaves d_next equal to the full word.
  assign shift_en = accept && !at_last;
`else
  assign shift_en = accept;
`endif

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .ser_in   (ser_in),
    .d_next   (word_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      par_out <= '0;
      state   <= S_EMPTY;
`ifdef SIPO_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      if (accept) bit_cnt <= complete ? '0 : bit_cnt + CW'(1);

      // A completion on the same edge as a pop reloads the holding register with no bubble.
      if (complete) begin
        par_out <= word_next;
        state   <= S_FULL;
`ifdef SIPO_PARITY_EN
        par_err <= ^{word_next, ser_in};
`endif
      end else if (pop) begin
        state <= S_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus.
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam int BPW  = W + 1;
  localparam int LAST = W;
`else
  localparam int BPW  = W;
  localparam int LAST = W - 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_in = 1'b0;
  logic ser_valid = 1'b0;
  logic par_ready = 1'b0;

  logic          ser_ready_m, ser_ready_l;
  logic [W-1:0]  par_out_m, par_out_l;
  logic          par_valid_m, par_valid_l;
  logic [CW-1:0] bit_cnt_m, bit_cnt_l;
`ifdef SIPO_PARITY_EN
  logic          par_err_m, par_err_l;
`endif

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready_m),
    .par_out   (par_out_m),
    .par_valid (par_valid_m),
    .par_ready (par_ready),
`ifdef SIPO_PARITY_EN
    .par_err   (par_err_m),
`endif
    .bit_cnt   (bit_cnt_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready_l),
    .par_out   (par_out_l),
    .par_valid (par_valid_l),
    .par_ready (par_ready),
`ifdef SIPO_PARITY_EN
    .par_err   (par_err_l),
`endif
    .bit_cnt   (bit_cnt_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  bit   cur_bits[$];
  int   model_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_ready = 1'b0;
  bit   mon_exp_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: bit i of a word lands at W-1-i (MSB-first) or i (LSB-first).
  task automatic model_accept(input bit b);
    exp_t e;
    cur_bits.push_back(b);
    model_cnt++;
    if (model_cnt == BPW) begin
      e.msb = '0;
      e.lsb = '0;
      e.err = 1'b0;
      for (int i = 0; i < W; i++) begin
        e.msb[W-1-i] = cur_bits[i];
        e.lsb[i]     = cur_bits[i];
      end
      for (int i = 0; i < BPW; i++) e.err = e.err ^ cur_bits[i];
      exp_q.push_back(e);
      cur_bits.delete();
      model_cnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_bits.delete();
    model_cnt = 0;
  endtask

  // Monitor: compares every observable output against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("bit_cnt_m", 32'(bit_cnt_m), 32'(model_cnt));
      check("bit_cnt_l", 32'(bit_cnt_l), 32'(model_cnt));
      mon_exp_rdy = !(model_cnt == LAST && exp_q.size() > 0 && !par_ready);
      check("ser_ready_m", 32'(ser_ready_m), 32'(mon_exp_rdy));
      check("ser_ready_l", 32'(ser_ready_l), 32'(mon_exp_rdy));
      check("par_valid_m", 32'(par_valid_m), 32'(exp_q.size() > 0));
      check("par_valid_l", 32'(par_valid_l), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("par_out_m", 32'(par_out_m), 32'(exp_q[0].msb));
        check("par_out_l", 32'(par_out_l), 32'(exp_q[0].lsb));
`ifdef SIPO_PARITY_EN
        check("par_err_m", 32'(par_err_m), 32'(exp_q[0].err));
        check("par_err_l", 32'(par_err_l), 32'(exp_q[0].err));
`endif
        if (par_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Returns one time unit after the accepting edge.
  task automatic send_bit(input bit b);
    bit rdy;
    bit done;
    done = 1'b0;
    ser_valid = 1'b1;
    ser_in = b;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      rdy = ser_ready_m;
      @(posedge clk);
      if (rdy) begin
        model_accept(b);
        done = 1'b1;
      end
      #1;
      if (rand_ready) par_ready = ($urandom_range(0, 2) != 0);
    end
    ser_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_vec(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) par_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic drain();
    par_ready = 1'b1;
    @(posedge clk);
    #1;
    par_ready = 1'b0;
    check("drained_valid", 32'(par_valid_m), 32'd0);
  endtask

  // Called one unit after an edge; the whole pulse fits before the next falling edge.
  task automatic pulse_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_bit_cnt"}, 32'(bit_cnt_m), 32'd0);
    check({tag, "_par_valid"}, 32'(par_valid_m), 32'd0);
    check({tag, "_par_out_m"}, 32'(par_out_m), 32'd0);
    check({tag, "_par_out_l"}, 32'(par_out_l), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_bit_cnt", 32'(bit_cnt_m), 32'd0);
    check("reset_par_valid", 32'(par_valid_m), 32'd0);
    check("reset_par_out", 32'(par_out_m), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_ser_ready", 32'(ser_ready_m), 32'd1);

    // Partial word discarded by an asynchronous reset between edges.
    send_vec(32'b101, 3);
    check("partial_bit_cnt", 32'(bit_cnt_m), 32'd3);
    pulse_reset("midword");

    // First word B2, held with par_ready low.
    send_vec(32'hB2, 8);
`ifdef SIPO_PARITY_EN
    check("no_valid_before_parity", 32'(par_valid_m), 32'd0);
    send_bit(1'b0);
    check("parity_ok_err_m", 32'(par_err_m), 32'd0);
    check("parity_ok_err_l", 32'(par_err_l), 32'd0);
`endif
    check("word1_valid", 32'(par_valid_m), 32'd1);
    check("word1_msb", 32'(par_out_m), 32'hB2);
    check("word1_lsb", 32'(par_out_l), 32'h4D);
    drain();

    // Bubbles in the middle of a word.
    send_vec(32'hB, 4);
    idle(5);
    check("bubble_bit_cnt", 32'(bit_cnt_m), 32'd4);
    check("bubble_no_valid", 32'(par_valid_m), 32'd0);
    send_vec(32'h2, 4);
`ifdef SIPO_PARITY_EN
    check("no_valid_before_parity2", 32'(par_valid_m), 32'd0);
    send_bit(1'b1);
    check("parity_bad_err_m", 32'(par_err_m), 32'd1);
`endif
    check("bubble_word_valid", 32'(par_valid_m), 32'd1);
    check("bubble_word_msb", 32'(par_out_m), 32'hB2);

    // Backpressure on the completing bit, then a same-edge pop and completion.
`ifdef SIPO_PARITY_EN
    send_vec(32'h5C, 8);
`else
    send_vec(32'h2E, 7);
`endif
    check("bp_bit_cnt", 32'(bit_cnt_m), 32'(LAST));
    ser_valid = 1'b1;
    ser_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_ser_ready", 32'(ser_ready_m), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_held_bit_cnt", 32'(bit_cnt_m), 32'(LAST));
    check("bp_held_word", 32'(par_out_m), 32'hB2);
    par_ready = 1'b1;
    send_bit(1'b0);
    par_ready = 1'b0;
    check("same_edge_valid", 32'(par_valid_m), 32'd1);
    check("same_edge_msb", 32'(par_out_m), 32'h5C);
    check("same_edge_lsb", 32'(par_out_l), 32'h3A);

    // Asynchronous reset while a word is held.
    pulse_reset("holding");

    // Randomized traffic: random bits, bubbles and consumer stalls.
    rand_ready = 1'b1;
    for (int w = 0; w < 40; w++) begin
      for (int b = 0; b < BPW; b++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        send_bit(1'($urandom_range(0, 1)));
      end
    end
    rand_ready = 1'b0;
    par_ready = 1'b1;
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
